case_6_prod_accum_11s: RTL
==========================

Name: case_6_prod_accum_11s

Overview:
Downstream consumer of the case_6 signed 11-bit product stage. It accepts a burst of LEN truncated signed products over a valid/ready handshake and accumulates them into a wider signed register. It presents the sum once on an output handshake. It closes the multiply loop into a dot-product style reduction for the case_6 datapath.

Parameters:
DIN_WIDTH, 11, width of the signed product input (matches multiplier dout width).
ACC_WIDTH, 24, width of the signed accumulator and result; must be >= DIN_WIDTH.
LEN_WIDTH, 8, width of the burst-length field; max burst 2^LEN_WIDTH-1 beats.

Ports:
ap_clk  in  1  clock, rising edge.
ap_rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
len  in  LEN_WIDTH  unsigned beat count, latched with start.
prod_din  in  DIN_WIDTH  signed product beat.
prod_valid  in  1  prod_din valid.
prod_ready  out  1  block accepts prod_din this cycle.
acc_dout  out  ACC_WIDTH  signed accumulated result, registered.
acc_valid  out  1  acc_dout valid.
acc_ready  in  1  downstream accepts acc_dout.
busy  out  1  high whenever state != IDLE.
ovf  out  1  sticky overflow flag for the current/last burst.

Behaviour:
- Reset (async, ap_rst_n=0): state=IDLE; acc register=0; beat counter=0; prod_ready=0, acc_valid=0, acc_dout=0, busy=0, ovf=0. Reset mid-burst abandons the burst. No result is emitted. Beats in flight are dropped.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - prod_ready=0.
  - On start=1 and len!=0: latch len into counter, clear acc and ovf, go to ACCUM.
  - On start=1 and len==0: clear acc and ovf, go to DONE. Result is 0.
  - start in any other state is ignored.
- ACCUM:
  - prod_ready=1 (combinational from state).
  - A beat transfers when prod_valid and prod_ready are both 1.
  - On each transfer: acc <= acc + sign_extend(prod_din) to ACC_WIDTH; counter decrements.
  - When the transferring beat has counter==1, go to DONE next cycle.
  - prod_valid=0 stalls with no state change. There is no timeout.
- DONE:
  - acc_valid=1, acc_dout=acc; both stay stable until acc_ready=1.
  - On acc_valid and acc_ready both 1: go to IDLE next cycle and deassert acc_valid. acc_dout holds its value.
  - prod_ready=0.
- Latency: acc_valid rises on the cycle after the last beat transfer (1 cycle). For len==0 it rises the cycle after start. The earliest next start is the cycle after the result handshake.
- Arithmetic: two's complement. Overflow is detected when both operand signs are equal and the sum sign differs. Overflow handling is set by the optional feature below.
- ovf is cleared only by reset or an accepted start.

Optional Feature:
Macro CASE6_ACC_SATURATE_EN.
- Defined:
  - Positive overflow clamps acc to 2^(ACC_WIDTH-1)-1.
  - Negative overflow clamps acc to -2^(ACC_WIDTH-1).
  - ovf is set sticky.
  - Later beats continue from the clamped value.
- Undefined:
  - The sum wraps modulo 2^ACC_WIDTH.
  - ovf is still set sticky on the overflow condition, so software can detect the wrap.

Test Plan:
1. Basic burst: start, len=4; beats 100, -50, 1023, -1024, all with prod_valid=1 -> acc_valid one cycle after 4th beat, acc_dout=49, ovf=0.
2. Backpressure:
   - Stimulus: len=3; beats 5, 6, 7 with prod_valid gaps of 2 cycles; acc_ready held 0 for 5 cycles.
   - Required: acc_dout=18 stable with acc_valid=1 throughout the hold; IDLE the cycle after acc_ready=1.
3. Zero length: start, len=0 -> prod_ready never asserts; acc_valid next cycle with acc_dout=0.
4. Overflow at ACC_WIDTH=12: len=3, beats 1023×3.
   - With CASE6_ACC_SATURATE_EN: acc_dout=2047, ovf=1.
   - Without it: acc_dout=-1027 (3069 wrapped), ovf=1.
5. Reset mid-burst: len=5, accept 2 beats, pulse ap_rst_n low asynchronously -> all outputs 0 immediately, busy=0. A new start with len=1, beat -7 yields acc_dout=-7, ovf=0.
6. Start while busy: second start during ACCUM, len=9 -> ignored; the original len=2 burst of 3, 4 completes with acc_dout=7.

Source files
------------

// File: rtl/case_6_prod_accum_11s.sv
//-----------------------------------------------------------------------------
// case_6_prod_accum_11s
//
// Purpose:
//   Dot-product style reducer for the case_6 datapath. After a one-cycle
//   start request it accepts a burst of `len` signed products over a
//   valid/ready handshake. Each product is sign-extended and added into a
//   wider signed accumulator. The final sum is then offered once on an
//   output valid/ready handshake.
//
// Optional feature (compile-time macro CASE6_ACC_SATURATE_EN):
//   defined   - on overflow the accumulator clamps to the most positive or
//               most negative value, and later beats continue from the clamp.
//   undefined - the accumulator wraps modulo 2^ACC_WIDTH.
//   In both builds the ovf output is a sticky overflow flag.
//
// Ports:
//   ap_clk      in   1          clock, rising edge
//   ap_rst_n    in   1          asynchronous active-low reset
//   start       in   1          begin a burst (sampled only in IDLE)
//   len         in   LEN_WIDTH  unsigned beat count, latched with start
//   prod_din    in   DIN_WIDTH  signed product beat
//   prod_valid  in   1          prod_din valid
//   prod_ready  out  1          block accepts prod_din (high in ACCUM)
//   acc_dout    out  ACC_WIDTH  signed result, registered, holds after handoff
//   acc_valid   out  1          acc_dout valid (high in DONE)
//   acc_ready   in   1          downstream accepts acc_dout
//   busy        out  1          high whenever the FSM is not IDLE
//   ovf         out  1          sticky overflow flag for the current/last burst
//-----------------------------------------------------------------------------
module case_6_prod_accum_11s #(
  parameter int DIN_WIDTH = 11,
  parameter int ACC_WIDTH = 24,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [DIN_WIDTH-1:0] prod_din,
  input  logic                 prod_valid,
  output logic                 prod_ready,
  output logic [ACC_WIDTH-1:0] acc_dout,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic                 busy,
  output logic                 ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

`ifdef CASE6_ACC_SATURATE_EN
  // Clamp limits of the signed accumulator.
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  // Sign-extend one product beat to the accumulator width.
  function automatic logic [ACC_WIDTH-1:0] sext_din(input logic [DIN_WIDTH-1:0] d);
    sext_din = ACC_WIDTH'($signed(d));
  endfunction

  // Two's complement add overflow: operands agree in sign, sum does not.
  function automatic logic add_ovf(input logic [ACC_WIDTH-1:0] a,
                                   input logic [ACC_WIDTH-1:0] b,
                                   input logic [ACC_WIDTH-1:0] s);
    add_ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
  endfunction

  state_t               state_q,     state_d;
  logic [LEN_WIDTH-1:0] cnt_q,       cnt_d;
  logic [ACC_WIDTH-1:0] acc_q,       acc_d;
  logic                 ovf_q,       ovf_d;
  logic [ACC_WIDTH-1:0] acc_dout_q,  acc_dout_d;
  logic                 acc_valid_q, acc_valid_d;

  logic [ACC_WIDTH-1:0] beat_ext;
  logic [ACC_WIDTH-1:0] sum_raw;
  logic                 sum_ovf;
  logic [ACC_WIDTH-1:0] acc_upd;

  // Accumulator update candidate for the beat currently on prod_din.
  always_comb begin
    beat_ext = sext_din(prod_din);
    sum_raw  = acc_q + beat_ext;
    sum_ovf  = add_ovf(acc_q, beat_ext, sum_raw);
`ifdef CASE6_ACC_SATURATE_EN
    // An overflow can only happen when both operands share the sign of
    // acc_q, so that sign picks the clamp direction.
    if (sum_ovf) begin
      if (acc_q[ACC_WIDTH-1]) begin
        acc_upd = ACC_MIN;
      end else begin
        acc_upd = ACC_MAX;
      end
    end else begin
      acc_upd = sum_raw;
    end
`else
    acc_upd = sum_raw;
`endif
  end

  // Next-state and next-register logic of the burst FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    acc_dout_d  = acc_dout_q;
    acc_valid_d = acc_valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = {ACC_WIDTH{1'b0}};
          ovf_d = 1'b0;
          if (len != {LEN_WIDTH{1'b0}}) begin
            cnt_d   = len;
            state_d = ACCUM;
          end else begin
            // Empty burst: the result (zero) is offered on the next cycle.
            cnt_d       = {LEN_WIDTH{1'b0}};
            acc_dout_d  = {ACC_WIDTH{1'b0}};
            acc_valid_d = 1'b1;
            state_d     = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ACCUM: begin
        if (prod_valid) begin
          acc_d = acc_upd;
          ovf_d = ovf_q | sum_ovf;
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            // Last beat: load the result register directly from the update
            // so acc_valid rises on the very next cycle.
            acc_dout_d  = acc_upd;
            acc_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end

      DONE: begin
        if (acc_ready) begin
          acc_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        acc_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {LEN_WIDTH{1'b0}};
      acc_q       <= {ACC_WIDTH{1'b0}};
      ovf_q       <= 1'b0;
      acc_dout_q  <= {ACC_WIDTH{1'b0}};
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      acc_dout_q  <= acc_dout_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    prod_ready = (state_q == ACCUM);
    busy       = (state_q != IDLE);
    acc_dout   = acc_dout_q;
    acc_valid  = acc_valid_q;
    ovf        = ovf_q;
  end

endmodule
